vu_meter: RTL and testbench



---
 rtl/audio_pkg.sv | 26 ++
 rtl/vu_level_enc.sv | 40 ++++
 rtl/vu_meter.sv | 152 +++++++++++++++
 tb/tb_vu_meter.sv | 305 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/audio_pkg.sv
// Shared audio-path definitions: sample width, full-scale codes and the
// saturating signed-to-magnitude conversion used by the level meter and the
// volume stage.
package audio_pkg;

  localparam int AUDIO_DW = 24;

  // Full-scale two's complement codes at the native sample width.
  localparam logic [AUDIO_DW-1:0] FS_POS = {1'b0, {(AUDIO_DW-1){1'b1}}};
  localparam logic [AUDIO_DW-1:0] FS_NEG = {1'b1, {(AUDIO_DW-1){1'b0}}};

  // Magnitude of a signed sample. The most negative code has no positive
  // counterpart, so it saturates to the largest positive magnitude.
  function automatic logic [AUDIO_DW-2:0] sat_mag(input logic [AUDIO_DW-1:0] s);
    logic [AUDIO_DW-1:0] neg;
    neg = AUDIO_DW'(0) - s;
    if (s == FS_NEG) begin
      return FS_POS[AUDIO_DW-2:0];
    end
    if (s[AUDIO_DW-1]) begin
      return neg[AUDIO_DW-2:0];
    end
    return s[AUDIO_DW-2:0];
  endfunction

endpackage

// File: rtl/vu_level_enc.sv
// Priority encoder from peak magnitude to bar-graph level, about 6 dB per
// LED: the most significant set bit picks the level, offset so the top
// magnitude bit lands on NLED, clamped to 0..NLED.
module vu_level_enc #(
  parameter int DW   = 24,
  parameter int NLED = 8,
  parameter int LW   = $clog2(NLED + 1)
) (
  input  logic [DW-2:0] mag_i,
  output logic [LW-1:0] level_o
);

  localparam int OFFSET = DW - 2 - NLED;

  int msb;
  int lvl;

  // Find the highest set bit, then shift and clamp it into the LED range.
  always_comb begin
    // NOTE: every variable gets a default before any branch, so no path can
    // leave one unassigned and infer a latch.
    msb     = -1;
    lvl     = 0;
    level_o = '0;
    for (int i = 0; i < DW - 1; i++) begin
      if (mag_i[i]) msb = i;
    end
    if (msb >= 0) begin
      lvl = msb - OFFSET;
      if (lvl <= 0) begin
        level_o = '0;
      end else if (lvl >= NLED) begin
        level_o = LW'(NLED);
      end else begin
        level_o = LW'(lvl);
      end
    end
  end

endmodule

// File: rtl/vu_meter.sv
// Stereo peak level meter. Stage 1 registers the louder channel's magnitude
// and a full-scale flag per frame; stage 2 quantises it and runs the bar
// ballistics (peak-hold then timed decay) and the clip hold counter. All
// timing is counted in frames; output updates two cycles after the strobe.
module vu_meter
  import audio_pkg::*;
#(
  parameter int DW           = AUDIO_DW,
  parameter int NLED         = 8,
  parameter int HOLD_FRAMES  = 24000,
  parameter int DECAY_FRAMES = 480,
  parameter int CLIP_FRAMES  = 12000
) (
  input  logic            clk,
  input  logic            rst,          // asynchronous, active-low
  input  logic            sample_valid,
  input  logic [DW-1:0]   adc_l,
  input  logic [DW-1:0]   adc_r,
  output logic [NLED-1:0] led,
  output logic            clip,
  output logic [DW-2:0]   peak_mag,
  output logic            level_valid
);

  localparam int LW  = $clog2(NLED + 1);
  localparam int HW  = $clog2(HOLD_FRAMES) + 1;
  localparam int DCW = $clog2(DECAY_FRAMES) + 1;
  localparam int CW  = $clog2(CLIP_FRAMES) + 1;

  // ---------------------------------------------------------------- stage 1
  // Samples are left-aligned to the package width so the shared saturating
  // magnitude function applies to any DW up to AUDIO_DW.
  logic [AUDIO_DW-1:0] l_al, r_al;
  logic [AUDIO_DW-2:0] l_mag_full, r_mag_full;
  logic [DW-2:0]       l_mag, r_mag;
  logic [DW-2:0]       s1_mag_d, s1_mag_q;
  logic                s1_clip_d, s1_clip_q;
  logic                s1_valid_q;

  assign l_al       = AUDIO_DW'(adc_l) << (AUDIO_DW - DW);
  assign r_al       = AUDIO_DW'(adc_r) << (AUDIO_DW - DW);
  assign l_mag_full = sat_mag(l_al);
  assign r_mag_full = sat_mag(r_al);
  assign l_mag      = l_mag_full[AUDIO_DW-2 -: DW-1];
  assign r_mag      = r_mag_full[AUDIO_DW-2 -: DW-1];
  assign s1_mag_d   = (l_mag > r_mag) ? l_mag : r_mag;

  // Clip is judged on the raw codes: either full-scale rail on either channel.
  assign s1_clip_d = (adc_l == FS_POS[AUDIO_DW-1 -: DW]) ||
                     (adc_l == FS_NEG[AUDIO_DW-1 -: DW]) ||
                     (adc_r == FS_POS[AUDIO_DW-1 -: DW]) ||
                     (adc_r == FS_NEG[AUDIO_DW-1 -: DW]);

  // Capture the frame's magnitude and clip flag on each strobe.
  always_ff @(posedge clk or negedge rst) begin
    // NOTE: non-blocking assignments so every register samples the values
    // from before this edge, independent of statement order.
    if (!rst) begin
      s1_valid_q <= 1'b0;
      s1_mag_q   <= '0;
      s1_clip_q  <= 1'b0;
    end else begin
      s1_valid_q <= sample_valid;
      if (sample_valid) begin
        s1_mag_q  <= s1_mag_d;
        s1_clip_q <= s1_clip_d;
      end
    end
  end

  // ---------------------------------------------------------------- stage 2
  logic [LW-1:0]  s1_level;
  logic [LW-1:0]  bar_d, bar_q;
  logic [HW-1:0]  hold_d, hold_q;
  logic [DCW-1:0] dcnt_d, dcnt_q;
  logic [CW-1:0]  ccnt_d, ccnt_q;
  logic [DW-2:0]  peak_d, peak_q;
  logic           lv_q;

  vu_level_enc #(
    .DW   (DW),
    .NLED (NLED),
    .LW   (LW)
  ) u_level_enc (
    .mag_i   (s1_mag_q),
    .level_o (s1_level)
  );

  // Bar ballistics and clip hold, advanced once per frame. A capture wins
  // over a decay tick due in the same frame; a new clip always reloads.
  always_comb begin
    bar_d  = bar_q;
    hold_d = hold_q;
    dcnt_d = dcnt_q;
    ccnt_d = ccnt_q;
    peak_d = peak_q;
    if (s1_valid_q) begin
      peak_d = s1_mag_q;

      if (s1_level >= bar_q) begin
        bar_d  = s1_level;
        hold_d = HW'(HOLD_FRAMES);
        dcnt_d = '0;
      end else if (hold_q != '0) begin
        hold_d = hold_q - HW'(1);
      end else if (dcnt_q == DCW'(DECAY_FRAMES - 1)) begin
        if (bar_q != '0) bar_d = bar_q - LW'(1);
        dcnt_d = '0;
      end else begin
        dcnt_d = dcnt_q + DCW'(1);
      end

      if (s1_clip_q) begin
        ccnt_d = CW'(CLIP_FRAMES);
      end else if (ccnt_q != '0) begin
        ccnt_d = ccnt_q - CW'(1);
      end
    end
  end

  // Stage-2 state; reset clears the meter and discards any frame in flight.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      bar_q  <= '0;
      hold_q <= '0;
      dcnt_q <= '0;
      ccnt_q <= '0;
      peak_q <= '0;
      lv_q   <= 1'b0;
    end else begin
      bar_q  <= bar_d;
      hold_q <= hold_d;
      dcnt_q <= dcnt_d;
      ccnt_q <= ccnt_d;
      peak_q <= peak_d;
      lv_q   <= s1_valid_q;
    end
  end

  // Thermometer decode of the bar height.
  always_comb begin
    led = '0;
    for (int i = 0; i < NLED; i++) begin
      led[i] = (int'(bar_q) > i);
    end
  end

  assign clip        = (ccnt_q != '0);
  assign peak_mag    = peak_q;
  assign level_valid = lv_q;

endmodule

// File: tb/tb_vu_meter.sv
// Self-checking bench for vu_meter with short ballistics parameters:
// table-driven single-frame quantisation vectors, hand-written multi-frame
// sequences, and randomized frames against a frame-level reference model.
module tb_vu_meter;

  localparam int DW    = 24;
  localparam int NLED  = 8;
  localparam int HOLD  = 4;
  localparam int DECAY = 2;
  localparam int CLIPF = 3;

  logic            clk = 1'b0;
  logic            rst = 1'b0;
  logic            sample_valid = 1'b0;
  logic [DW-1:0]   adc_l = '0;
  logic [DW-1:0]   adc_r = '0;
  logic [NLED-1:0] led;
  logic            clip;
  logic [DW-2:0]   peak_mag;
  logic            level_valid;

  vu_meter #(
    .DW           (DW),
    .NLED         (NLED),
    .HOLD_FRAMES  (HOLD),
    .DECAY_FRAMES (DECAY),
    .CLIP_FRAMES  (CLIPF)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .sample_valid (sample_valid),
    .adc_l        (adc_l),
    .adc_r        (adc_r),
    .led          (led),
    .clip         (clip),
    .peak_mag     (peak_mag),
    .level_valid  (level_valid)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // ------------------------------------------------------- reference model
  // Frame-level behaviour written straight from the meter's rules.
  int m_bar, m_hold, m_dcnt, m_ccnt, m_peak;

  function automatic int ref_mag(input logic [DW-1:0] s);
    int v;
    int m;
    v = int'($signed(s));
    m = (v < 0) ? -v : v;
    if (m > (1 << (DW - 1)) - 1) m = (1 << (DW - 1)) - 1;
    return m;
  endfunction

  function automatic int ref_level(input int mag);
    int lg;
    int l;
    if (mag == 0) return 0;
    lg = 0;
    while ((mag >> (lg + 1)) != 0) lg++;
    l = lg - (DW - 2 - NLED);
    if (l < 0) l = 0;
    if (l > NLED) l = NLED;
    return l;
  endfunction

  function automatic logic [7:0] led_of(input int bar);
    return 8'((1 << bar) - 1);
  endfunction

  task automatic model_reset();
    m_bar = 0; m_hold = 0; m_dcnt = 0; m_ccnt = 0; m_peak = 0;
  endtask

  task automatic model_frame(input logic [DW-1:0] l, input logic [DW-1:0] r);
    int ml, mr, lvl;
    bit clipd;
    ml     = ref_mag(l);
    mr     = ref_mag(r);
    m_peak = (ml > mr) ? ml : mr;
    lvl    = ref_level(m_peak);
    clipd  = (int'($signed(l)) == (1 << (DW - 1)) - 1) || (int'($signed(l)) == -(1 << (DW - 1))) ||
             (int'($signed(r)) == (1 << (DW - 1)) - 1) || (int'($signed(r)) == -(1 << (DW - 1)));
    if (lvl >= m_bar) begin
      m_bar = lvl; m_hold = HOLD; m_dcnt = 0;
    end else if (m_hold > 0) begin
      m_hold--;
    end else if (m_dcnt == DECAY - 1) begin
      m_bar  = (m_bar > 0) ? m_bar - 1 : 0;
      m_dcnt = 0;
    end else begin
      m_dcnt++;
    end
    if (clipd) m_ccnt = CLIPF;
    else if (m_ccnt > 0) m_ccnt--;
  endtask

  // ---------------------------------------------------------------- drivers
  // Inputs change on the falling edge; outputs are sampled there too.
  task automatic step(input logic v, input logic [DW-1:0] l, input logic [DW-1:0] r);
    sample_valid = v;
    adc_l        = l;
    adc_r        = r;
    @(negedge clk);
  endtask

  // One strobe, then one idle cycle: returns when that frame's result is
  // on the outputs with level_valid high.
  task automatic frame(input logic [DW-1:0] l, input logic [DW-1:0] r);
    step(1'b1, l, r);
    step(1'b0, '0, '0);
  endtask

  task automatic reset_dut();
    sample_valid = 1'b0;
    adc_l        = '0;
    adc_r        = '0;
    rst          = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    model_reset();
  endtask

  function automatic logic [DW-1:0] gen_sample();
    logic signed [DW-1:0] x;
    case ($urandom_range(0, 9))
      0, 1, 2: x = '0;
      3:       x = 24'h7FFFFF;
      4:       x = 24'h800000;
      5:       x = 24'h800001;
      default: begin
        x = DW'($urandom);
        x = x >>> $urandom_range(0, DW - 1);
      end
    endcase
    return x;
  endfunction

  typedef struct {
    logic [DW-1:0]   l;
    logic [DW-1:0]   r;
    logic [NLED-1:0] led;
    logic            clip;
    logic [DW-2:0]   peak;
  } vec_t;

  typedef struct {
    logic [NLED-1:0] led;
    logic            clip;
    logic [DW-2:0]   peak;
    logic            lv;
  } exp_t;

  vec_t tbl[12];

  initial begin
    #2ms;
    $display("FAIL timeout: simulation did not finish, expected completion");
    $fatal(1, "timeout");
  end

  initial begin
    exp_t exp_prev, exp_cur;

    tbl[0]  = '{24'h400000, 24'h000000, 8'hFF, 1'b0, 23'h400000};
    tbl[1]  = '{24'hFF8000, 24'h000000, 8'h01, 1'b0, 23'h008000};
    tbl[2]  = '{24'h004000, 24'h000000, 8'h00, 1'b0, 23'h004000};
    tbl[3]  = '{24'h000000, 24'h800000, 8'hFF, 1'b1, 23'h7FFFFF};
    tbl[4]  = '{24'h7FFFFF, 24'h000000, 8'hFF, 1'b1, 23'h7FFFFF};
    tbl[5]  = '{24'h800001, 24'h000000, 8'hFF, 1'b0, 23'h7FFFFF};
    tbl[6]  = '{24'h000000, 24'h000000, 8'h00, 1'b0, 23'h000000};
    tbl[7]  = '{24'h000001, 24'h000000, 8'h00, 1'b0, 23'h000001};
    tbl[8]  = '{24'h010000, 24'h000000, 8'h03, 1'b0, 23'h010000};
    tbl[9]  = '{24'h200000, 24'h000000, 8'h7F, 1'b0, 23'h200000};
    tbl[10] = '{24'hC00000, 24'h000000, 8'hFF, 1'b0, 23'h400000};
    tbl[11] = '{24'h000100, 24'hFFF000, 8'h00, 1'b0, 23'h001000};

    // Reset state, checked while reset is still held.
    rst = 1'b0;
    repeat (2) @(negedge clk);
    check("reset_led", 32'(led), 32'h00);
    check("reset_clip", 32'(clip), 32'h0);
    check("reset_peak", 32'(peak_mag), 32'h0);
    check("reset_lv", 32'(level_valid), 32'h0);
    rst = 1'b1;
    @(negedge clk);

    // Single-frame quantisation table, each from a cold meter.
    foreach (tbl[i]) begin
      reset_dut();
      frame(tbl[i].l, tbl[i].r);
      check($sformatf("tbl%0d_led", i), 32'(led), 32'(tbl[i].led));
      check($sformatf("tbl%0d_clip", i), 32'(clip), 32'(tbl[i].clip));
      check($sformatf("tbl%0d_peak", i), 32'(peak_mag), 32'(tbl[i].peak));
      check($sformatf("tbl%0d_lv", i), 32'(level_valid), 32'h1);
    end

    // Ballistics: full bar, hold for HOLD frames, then one LED per DECAY frames.
    reset_dut();
    frame(24'h400000, '0);
    for (int k = 1; k <= 20; k++) begin
      int eb;
      frame('0, '0);
      eb = (k <= 5) ? 8 : 8 - (k - 4) / 2;
      if (eb < 0) eb = 0;
      check($sformatf("decay_led_f%0d", k), 32'(led), 32'(led_of(eb)));
    end

    // Capture during decay, landing on the frame where a decay tick is due.
    reset_dut();
    frame(24'h400000, '0);
    for (int k = 1; k <= 11; k++) frame('0, '0);
    check("capture_pre_led", 32'(led), 32'h1F);
    frame(24'h100000, '0);
    check("capture_led", 32'(led), 32'h3F);
    for (int j = 1; j <= 6; j++) begin
      frame('0, '0);
      check($sformatf("capture_hold_f%0d", j), 32'(led), (j <= 5) ? 32'h3F : 32'h1F);
    end

    // Clip indicator and its frame-counted hold.
    reset_dut();
    frame('0, 24'h800000);
    check("clip_peak", 32'(peak_mag), 32'h7FFFFF);
    check("clip_led", 32'(led), 32'hFF);
    check("clip_flag", 32'(clip), 32'h1);
    for (int j = 1; j <= 3; j++) begin
      frame('0, '0);
      check($sformatf("clip_hold_f%0d", j), 32'(clip), (j < 3) ? 32'h1 : 32'h0);
    end

    // Back-to-back strobes in consecutive cycles.
    reset_dut();
    step(1'b1, 24'h100000, '0);
    check("b2b_lv_n1", 32'(level_valid), 32'h0);
    step(1'b1, 24'h400000, '0);
    check("b2b_led_n2", 32'(led), 32'h3F);
    check("b2b_lv_n2", 32'(level_valid), 32'h1);
    step(1'b0, '0, '0);
    check("b2b_led_n3", 32'(led), 32'hFF);
    check("b2b_lv_n3", 32'(level_valid), 32'h1);
    step(1'b0, '0, '0);
    check("b2b_lv_n4", 32'(level_valid), 32'h0);
    check("b2b_led_n4", 32'(led), 32'hFF);

    // Asynchronous reset mid-stream with frames in flight.
    reset_dut();
    frame(24'h7FFFFF, '0);
    check("areset_pre_led", 32'(led), 32'hFF);
    step(1'b1, 24'h400000, '0);
    #2 rst = 1'b0;
    #1;
    check("areset_led", 32'(led), 32'h00);
    check("areset_clip", 32'(clip), 32'h0);
    check("areset_peak", 32'(peak_mag), 32'h0);
    check("areset_lv", 32'(level_valid), 32'h0);
    sample_valid = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    for (int j = 0; j < 3; j++) begin
      step(1'b0, '0, '0);
      check($sformatf("areset_flush_lv%0d", j), 32'(level_valid), 32'h0);
    end
    frame(24'h008000, '0);
    check("areset_cold_led", 32'(led), 32'h01);
    check("areset_cold_clip", 32'(clip), 32'h0);
    check("areset_cold_peak", 32'(peak_mag), 32'h008000);

    // Randomized frames, including back-to-back strobes, against the model.
    reset_dut();
    exp_prev = '{8'h00, 1'b0, 23'h0, 1'b0};
    for (int k = 0; k < 800; k++) begin
      logic v;
      logic [DW-1:0] l, r;
      v = ($urandom_range(0, 2) != 0);
      l = gen_sample();
      r = gen_sample();
      if (v) model_frame(l, r);
      exp_cur = '{led_of(m_bar), (m_ccnt != 0), DW'(m_peak), v};
      step(v, l, r);
      if (k > 0) begin
        check("rand_led", 32'(led), 32'(exp_prev.led));
        check("rand_clip", 32'(clip), 32'(exp_prev.clip));
        check("rand_peak", 32'(peak_mag), 32'(exp_prev.peak));
        check("rand_lv", 32'(level_valid), 32'(exp_prev.lv));
      end
      exp_prev = exp_cur;
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
